pulse_stretch: RTL
==================

Name: pulse_stretch

Overview:
- Converse of the input debouncer: takes single-cycle event pulses (button edges, RTC tick and alarm strobes) and turns each one into a stable, human-visible output level for an LED, buzzer or external pin.
- Every accepted event produces one distinct blink: a fixed ON period followed by a fixed OFF gap.
- Events arriving during a blink are queued in a saturating pending counter, so bursts are shown as separate blinks rather than merged.

Parameters:
- ON_CYC, 1024, cycles out_state is held high per blink (>=1)
- OFF_CYC, 1024, cycles out_state is held low between blinks (>=1)
- PEND_MAX, 7, maximum queued events (>=1); PEND_W = $clog2(PEND_MAX+1)

Ports:
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- in_edge  in  1  event strobe, sampled on posedge clk; each high cycle is one event
- out_state  out  1  stretched output level
- busy  out  1  high whenever state != IDLE
- pend  out  PEND_W  number of queued events
- overflow  out  1  one-cycle pulse when an event is dropped

Behaviour:
- All outputs are registered. Reset values: state IDLE, out_state 0, busy 0, pend 0, overflow 0, timer 0.
- States: IDLE, ON, GAP. A single timer counts 0..max(ON_CYC,OFF_CYC)-1 and is cleared on every state entry.
- IDLE: out_state=0. If in_edge is high at posedge k, the block enters ON and out_state is high from cycle k+1 (1-cycle latency). pend is untouched.
- ON: out_state=1 for exactly ON_CYC cycles. At timer==ON_CYC-1 -> GAP.
- GAP: out_state=0 for exactly OFF_CYC cycles. At timer==OFF_CYC-1:
  - if pend>0: pend-1, -> ON.
  - else if in_edge is high that same cycle: -> ON, pend stays 0.
  - else -> IDLE.
- in_edge while in ON or GAP (excluding the GAP-end cases above):
  - pend+1 if pend<PEND_MAX.
  - otherwise the event is dropped and overflow is high the next cycle.
- Simultaneous in_edge and consume at GAP end with pend>0: net pend unchanged. No overflow, even at PEND_MAX, because a slot frees that cycle.
- Back-to-back blinks insert no IDLE cycle between GAP end and the next ON.
- Reset asserted mid-blink aborts immediately (asynchronous): all outputs return to reset values and queued events are discarded. After reset release, no blink occurs without a new in_edge.
- in_edge held high for N cycles counts as N events (no edge detection inside; upstream supplies clean one-cycle edges).
- No combinational path from in_edge to any output.

Decomposition:
- No shared package is needed. State encoding is a localparam in this module.
- Timer: one instance of the team's generic `counter` module (clk, clrn, ena, active-low synchronous load ldn, d, q), width $clog2(max(ON_CYC,OFF_CYC)). ldn is asserted low with d=0 on every state transition.
- Pending counter and FSM are inline. No other sub-module.

Test Plan:
(ON_CYC=4, OFF_CYC=3, PEND_MAX=2; cycle numbers refer to posedge k)
- Single event: in_edge at 10 -> out_state high cycles 11-14, low from 15; busy high 11-17, low at 18; pend stays 0.
- Burst: in_edge at 10, 12, 13 -> pend=2 by cycle 14; blinks at 11-14, 18-21, 25-28; pend 1 at 18, 0 at 25; busy low at 32.
- Overflow: in_edge at 10, 12, 13, 14 -> overflow high only at cycle 15; pend stays 2; exactly three blinks, as in the burst case.
- GAP-end coincidence, two sub-cases:
  - pend=0, in_edge at 17 (last GAP cycle) -> ON at 18 with no IDLE cycle; pend stays 0.
  - pend=2, in_edge at 17 -> pend stays 2; overflow stays 0.
- Reset mid-blink: events at 10, 12; clrn low during cycle 13 -> out_state, busy, pend immediately 0. Release at 16 with no in_edge -> out_state stays 0 for 50 cycles.

Source files
------------

// File: rtl/counter.sv
// Generic up-counter with active-low synchronous load, shared across the codebase.
// Load takes priority over count enable.
module counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ena,
    input  logic             ldn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_q <= '0;
        end else if (!ldn) begin
            r_q <= d;
        end else if (ena) begin
            r_q <= r_q + ONE;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into visible blinks (ON period, then OFF gap),
// queueing events that arrive mid-blink in a saturating pending counter.
module pulse_stretch #(
    parameter int unsigned ON_CYC   = 1024,
    parameter int unsigned OFF_CYC  = 1024,
    parameter int unsigned PEND_MAX = 7,
    localparam int unsigned PEND_W  = $clog2(PEND_MAX + 1)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              in_edge,
    output logic              out_state,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              overflow
);

    localparam int unsigned MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0]  ON_LAST   = TMR_W'(ON_CYC - 1);
    localparam logic [TMR_W-1:0]  OFF_LAST  = TMR_W'(OFF_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [PEND_W-1:0]  r_pend;
    logic [PEND_W-1:0]  w_pend_d;
    logic               r_out;
    logic               r_busy;
    logic               r_overflow;
    logic               w_drop;
    logic               w_tmr_ena;
    logic               w_tmr_ldn;
    logic [TMR_W-1:0]   w_tmr;

    // Timer restarts from zero on every state entry.
    counter #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk (clk),
        .clrn(clrn),
        .ena (w_tmr_ena),
        .ldn (w_tmr_ldn),
        .d   ({TMR_W{1'b0}}),
        .q   (w_tmr)
    );

    assign w_tmr_ena = (r_state != StIdle);
    assign w_tmr_ldn = (w_state_d == r_state);

    always_comb begin
        w_state_d = r_state;
        w_pend_d  = r_pend;
        w_drop    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_edge) begin
                    w_state_d = StOn;
                end
            end
            StOn: begin
                if (w_tmr == ON_LAST) begin
                    w_state_d = StGap;
                end
                if (in_edge) begin
                    if (r_pend < PEND_FULL) begin
                        w_pend_d = r_pend + PEND_ONE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            StGap: begin
                if (w_tmr == OFF_LAST) begin
                    // A fresh event during the consume cycle reuses the freed slot.
                    if (r_pend != '0) begin
                        w_state_d = StOn;
                        if (!in_edge) begin
                            w_pend_d = r_pend - PEND_ONE;
                        end
                    end else if (in_edge) begin
                        w_state_d = StOn;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (in_edge) begin
                    if (r_pend < PEND_FULL) begin
                        w_pend_d = r_pend + PEND_ONE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= StIdle;
            r_pend     <= '0;
            r_out      <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pend     <= w_pend_d;
            r_out      <= (w_state_d == StOn);
            r_busy     <= (w_state_d != StIdle);
            r_overflow <= w_drop;
        end
    end

    assign out_state = r_out;
    assign busy      = r_busy;
    assign pend      = r_pend;
    assign overflow  = r_overflow;

endmodule
